// File: rtl/digiclock_pkg.sv
// Shared types and limits for the digital clock time-keeping slice.
// Limits are packed-BCD so they compare directly against counter values.
package digiclock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Packed BCD orders the same way as binary, so a plain compare bounds the tens digit.
    function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max_bcd);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_bcd);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD modulo counter (0 .. MAX_BCD).
// Priority: clear, then load, then increment. carry_o flags the wrap.
module bcd2_counter
    import digiclock_pkg::*;
#(
    parameter logic [7:0] MAX_BCD  = 8'h59,
    parameter logic [7:0] INIT_BCD = 8'h00
) (
    input  logic       clk_100M,
    input  logic       sys_rst_p,
    input  logic       inc,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_o
);

    if (!bcd_legal(INIT_BCD, MAX_BCD)) begin : g_init_check
        $error("bcd2_counter: INIT_BCD %h is not legal BCD within 00..%h", INIT_BCD, MAX_BCD);
    end

    logic [7:0] value_reg;
    logic [7:0] value_next;
    logic       at_max;

    assign at_max  = (value_reg == MAX_BCD);
    assign carry_o = inc & at_max;
    assign value   = value_reg;

    always_comb begin
        value_next = value_reg;
        if (at_max) begin
            value_next = 8'h00;
        end else if (value_reg[3:0] == 4'd9) begin
            value_next = {value_reg[7:4] + 4'd1, 4'd0};
        end else begin
            value_next = {value_reg[7:4], value_reg[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk_100M or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            value_reg <= INIT_BCD;
        end else if (clear) begin
            value_reg <= 8'h00;
        end else if (load) begin
            value_reg <= load_val;
        end else if (inc) begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/time_counter_bcd.sv
// Time-of-day core: 24 h packed-BCD hh:mm:ss with run / set-hour / set-minute modes.
// clk_1Hz comes from a clk_100M flop and is edge-detected here as plain data.
module time_counter_bcd
    import digiclock_pkg::*;
#(
    parameter logic [7:0] INIT_HH = 8'h00,
    parameter logic [7:0] INIT_MM = 8'h00,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic       clk_100M,
    input  logic       sys_rst_p,
    input  logic       clk_1Hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_tick
);

    mode_t mode_reg;
    logic  hz_d_reg;
    logic  hz_seen_low_reg;
    logic  sec_tick_reg;
    logic  day_tick_reg;

    logic tick_c;
    logic run;
    logic sec_inc, min_inc, hour_inc;
    logic sec_clear;
    logic sec_carry, min_carry, hour_carry;

    // A rise only counts once clk_1Hz has been seen low since reset, so a level
    // held high through reset release does not fake a tick.
    assign tick_c = clk_1Hz & ~hz_d_reg & hz_seen_low_reg;
    assign run    = (mode_reg == MODE_RUN);

    always_ff @(posedge clk_100M or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            hz_d_reg        <= 1'b0;
            hz_seen_low_reg <= 1'b0;
        end else begin
            hz_d_reg <= clk_1Hz;
            if (!clk_1Hz) begin
                hz_seen_low_reg <= 1'b1;
            end
        end
    end

    // Mode change beats a same-cycle increment; carries only ripple while running.
    assign sec_inc   = run & tick_c;
    assign min_inc   = run ? sec_carry
                           : ((mode_reg == MODE_SET_MIN) & btn_inc & ~btn_mode);
    assign hour_inc  = run ? min_carry
                           : ((mode_reg == MODE_SET_HOUR) & btn_inc & ~btn_mode);
    assign sec_clear = (mode_reg == MODE_SET_MIN) & btn_mode;

    bcd2_counter #(.MAX_BCD(SEC_MAX), .INIT_BCD(INIT_SS)) u_sec (
        .clk_100M (clk_100M),
        .sys_rst_p(sys_rst_p),
        .inc      (sec_inc),
        .clear    (sec_clear),
        .load     (1'b0),
        .load_val (8'h00),
        .value    (sec_bcd),
        .carry_o  (sec_carry)
    );

    bcd2_counter #(.MAX_BCD(MIN_MAX), .INIT_BCD(INIT_MM)) u_min (
        .clk_100M (clk_100M),
        .sys_rst_p(sys_rst_p),
        .inc      (min_inc),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .value    (min_bcd),
        .carry_o  (min_carry)
    );

    bcd2_counter #(.MAX_BCD(HOUR_MAX), .INIT_BCD(INIT_HH)) u_hour (
        .clk_100M (clk_100M),
        .sys_rst_p(sys_rst_p),
        .inc      (hour_inc),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .value    (hour_bcd),
        .carry_o  (hour_carry)
    );

    always_ff @(posedge clk_100M or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            mode_reg     <= MODE_RUN;
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg <= tick_c;
            day_tick_reg <= hour_carry & run;
            if (btn_mode) begin
                case (mode_reg)
                    MODE_RUN:      mode_reg <= MODE_SET_HOUR;
                    MODE_SET_HOUR: mode_reg <= MODE_SET_MIN;
                    MODE_SET_MIN:  mode_reg <= MODE_RUN;
                    default:       mode_reg <= MODE_RUN;
                endcase
            end
        end
    end

    assign mode     = mode_reg;
    assign sec_tick = sec_tick_reg;
    assign day_tick = day_tick_reg;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Scoreboard bench for time_counter_bcd: driver pushes model predictions,
// a monitor pops and compares one expectation per clk_100M cycle.
module tb_time_counter_bcd;

    localparam logic [7:0] P_HH = 8'h23;
    localparam logic [7:0] P_MM = 8'h59;
    localparam logic [7:0] P_SS = 8'h58;

    logic       clk_100M  = 1'b0;
    logic       sys_rst_p = 1'b1;
    logic       clk_1Hz   = 1'b0;
    logic       btn_mode  = 1'b0;
    logic       btn_inc   = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       sec_tick, day_tick;

    time_counter_bcd #(.INIT_HH(P_HH), .INIT_MM(P_MM), .INIT_SS(P_SS)) dut (
        .clk_100M (clk_100M),
        .sys_rst_p(sys_rst_p),
        .clk_1Hz  (clk_1Hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .mode     (mode),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic [1:0] md;
        logic       st;
        logic       dt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain integers for time, 0/1/2 for the mode.
    int m_h, m_m, m_s, m_mode;
    bit m_prev;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v, input logic [7:0] mx);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= mx);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_h    = from_bcd(P_HH);
        m_m    = from_bcd(P_MM);
        m_s    = from_bcd(P_SS);
        m_mode = 0;
        m_prev = 1'b1;   // a rise needs clk_1Hz seen low after reset
    endfunction

    task automatic apply(input bit bm, input bit bi, input bit hz);
        bit   tick;
        bit   day;
        exp_t e;
        btn_mode = bm;
        btn_inc  = bi;
        clk_1Hz  = hz;
        tick   = hz && !m_prev;
        m_prev = hz;
        day    = 1'b0;
        case (m_mode)
            0: begin
                if (tick) begin
                    m_s++;
                    if (m_s == 60) begin
                        m_s = 0;
                        m_m++;
                        if (m_m == 60) begin
                            m_m = 0;
                            m_h++;
                            if (m_h == 24) begin
                                m_h = 0;
                                day = 1'b1;
                            end
                        end
                    end
                end
                if (bm) m_mode = 1;
            end
            1: begin
                if (bm) m_mode = 2;
                else if (bi) m_h = (m_h + 1) % 24;
            end
            default: begin
                if (bm) begin
                    m_mode = 0;
                    m_s    = 0;
                end else if (bi) begin
                    m_m = (m_m + 1) % 60;
                end
            end
        endcase
        e.hh = to_bcd(m_h);
        e.mm = to_bcd(m_m);
        e.ss = to_bcd(m_s);
        e.md = 2'(m_mode);
        e.st = tick;
        e.dt = day;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit bm, input bit bi, input bit hz);
        @(negedge clk_100M);
        apply(bm, bi, hz);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
    endtask

    task automatic incs(input int n);
        repeat (n) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic press_mode();
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    // From RUN: dial in h:m through the set modes, return to RUN (sec 00), tick s times.
    task automatic set_time(input int h, input int m, input int s);
        press_mode();
        incs((h - m_h + 24) % 24);
        press_mode();
        incs((m - m_m + 60) % 60);
        press_mode();
        ticks(s);
    endtask

    task automatic reset_mid(input bit hz);
        @(posedge clk_100M);
        #2;
        clk_1Hz   = hz;
        sys_rst_p = 1'b1;
        #1;
        chk("rst_hour", hour_bcd, P_HH);
        chk("rst_min", min_bcd, P_MM);
        chk("rst_sec", sec_bcd, P_SS);
        chk("rst_mode", {6'b0, mode}, 8'h00);
        chk("rst_sec_tick", {7'b0, sec_tick}, 8'h00);
        chk("rst_day_tick", {7'b0, day_tick}, 8'h00);
        model_reset();
        repeat (2) @(negedge clk_100M);
        sys_rst_p = 1'b0;
        apply(0, 0, hz);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_100M);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("hour", hour_bcd, e.hh);
                chk("min", min_bcd, e.mm);
                chk("sec", sec_bcd, e.ss);
                chk("mode", {6'b0, mode}, {6'b0, e.md});
                chk("sec_tick", {7'b0, sec_tick}, {7'b0, e.st});
                chk("day_tick", {7'b0, day_tick}, {7'b0, e.dt});
                chk("bcd_legal", {7'b0, (bcd_ok(hour_bcd, 8'h23) && bcd_ok(min_bcd, 8'h59)
                                         && bcd_ok(sec_bcd, 8'h59))}, 8'h01);
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (2) @(negedge clk_100M);
        chk("init_hour", hour_bcd, P_HH);
        chk("init_min", min_bcd, P_MM);
        chk("init_sec", sec_bcd, P_SS);
        chk("init_mode", {6'b0, mode}, 8'h00);
        chk("init_ticks", {6'b0, sec_tick, day_tick}, 8'h00);
        @(negedge clk_100M);
        sys_rst_p = 1'b0;
        apply(0, 0, 0);
        step(0, 0, 0);

        // 23:59:58 -> 23:59:59 -> 00:00:00 with day_tick, then reset on the day_tick cycle.
        ticks(1);
        step(0, 0, 1);
        reset_mid(1'b1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        ticks(2);

        set_time(9, 59, 59);
        ticks(1);
        set_time(19, 59, 59);
        ticks(1);

        set_time(22, 14, 30);
        press_mode();
        incs(3);
        ticks(5);
        press_mode();
        incs((59 - m_m + 60) % 60);
        incs(1);
        press_mode();
        ticks(1);

        set_time(5, 5, 5);
        step(1, 1, 0);
        step(0, 0, 0);
        press_mode();
        press_mode();
        ticks(5);
        step(1, 0, 1);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);
        press_mode();
        press_mode();

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                reset_mid(1'($urandom_range(0, 1)));
            end else begin
                step(($urandom % 12) == 0, ($urandom % 3) == 0,
                     (($urandom % 3) == 0) ? !clk_1Hz : clk_1Hz);
            end
        end

        repeat (3) @(posedge clk_100M);
        #2;
        chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_counter_bcd.md
Name: time_counter_bcd

Overview:
- Time-of-day core of the digital clock. Sits directly downstream of the 100 MHz to 1 Hz divider and consumes its clk_1Hz output as a data signal in the clk_100M domain.
- Keeps hours, minutes and seconds as packed BCD, in 24 h format.
- Provides a three-state set mode (run / set hour / set minute), driven by debounced single-cycle button pulses.
- Outputs feed the display multiplexer.

Parameters:
- INIT_HH, 8'h00, packed-BCD hour loaded on reset; legal range 00-23.
- INIT_MM, 8'h00, packed-BCD minute loaded on reset; legal range 00-59.
- INIT_SS, 8'h00, packed-BCD second loaded on reset; legal range 00-59.
- An out-of-range or non-BCD value is a configuration error and must be caught by an elaboration-time check.

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- sys_rst_p  in  1  reset; asynchronous, active-high.
- clk_1Hz  in  1  square wave from the divider. It is generated by a clk_100M flop, so no synchroniser is required.
- btn_mode  in  1  single-cycle pulse, debounced upstream; advances the mode.
- btn_inc  in  1  single-cycle pulse, debounced upstream; increments the selected field.
- hour_bcd  out  8  [7:4] tens, [3:0] ones.
- min_bcd  out  8  packed BCD.
- sec_bcd  out  8  packed BCD.
- mode  out  2  2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN. 2'b11 is never driven.
- sec_tick  out  1  one-cycle pulse for every clk_1Hz rising edge, in any mode. Used for colon and set-field blink.
- day_tick  out  1  one-cycle pulse when the time rolls over from 23:59:59 to 00:00:00.

Behaviour:
- Reset (asynchronous, takes effect immediately; mid-operation reset aborts any set in progress):
  - hour/min/sec = INIT_HH/INIT_MM/INIT_SS.
  - mode = RUN.
  - sec_tick = 0, day_tick = 0.
  - internal clk_1Hz delay flop = 0.
- Edge detect:
  - tick_c = clk_1Hz & ~clk_1Hz_d.
  - clk_1Hz_d <= clk_1Hz every cycle.
  - At the first clk_100M edge after clk_1Hz rises, sec_tick goes high for exactly 1 cycle and the counters update on that same edge. Latency is 1 cycle.
  - A clk_1Hz held high produces only one tick.
- RUN, on tick_c:
  - Seconds increment in BCD: the ones digit wraps 9 to 0 and carries into tens; 59 wraps to 00 and carries into minutes.
  - Minutes behave the same way (59 to 00) and carry into hours.
  - Hours wrap 23 to 00. 09 to 10 and 19 to 20 are tens carries.
  - day_tick is asserted on the same edge as the 23:59:59 to 00:00:00 update, for 1 cycle.
- Mode FSM:
  - Transitions on btn_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR freezes seconds. In both set modes tick_c does not change the time, but sec_tick still pulses.
  - SET_MIN -> RUN clears seconds to 00 on the transition edge.
- SET_HOUR: btn_inc adds 1 to hours, modulo 24. No carry to or from other fields.
- SET_MIN: btn_inc adds 1 to minutes, modulo 60. No carry into hours.
- btn_inc in RUN is ignored.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: the mode change wins and the increment is dropped.
  - tick_c and btn_mode in the same cycle while in RUN: the tick increment is applied and the mode advances to SET_HOUR on the same edge.
  - tick_c and btn_inc in the same cycle while in a set mode: the increment is applied. The tick is ignored as a time update, but sec_tick still pulses.
- Outputs:
  - All outputs are registered. No combinational path from inputs to outputs.
  - BCD digits are never outside 0-9. The tens digits are never outside 0-5 for min/sec and 0-2 for hour.

Decomposition:
- Package digiclock_pkg holds:
  - the mode typedef (RUN/SET_HOUR/SET_MIN encodings above);
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23.
- Sub-module bcd2_counter: two-digit packed-BCD modulo counter.
  - Parameter MAX_BCD.
  - Inputs: inc, clear, load with load value.
  - Outputs: value, and a combinational carry_o = inc & (value==MAX_BCD).
  - Instantiated three times.
- The top level contains the edge detect, the mode FSM, the increment-routing logic and the tick outputs.

Test Plan:
- INIT 23:59:58, then two clk_1Hz rising edges. After the first: 23:59:59. After the second: 00:00:00, with day_tick high for exactly 1 cycle on the same edge and sec_tick high for 1 cycle on each edge.
- INIT 09:59:59, one tick -> 10:00:00. Then 19:59:59 -> 20:00:00. Digits checked with a BCD-legal assertion on every cycle.
- At 22:14:30 in RUN: btn_mode -> mode 01. Then btn_inc x3 -> hours 23, 00, 01, with minutes unchanged at 14. Five ticks during SET_HOUR leave sec at 30; sec_tick pulses 5 times.
- In SET_MIN at minute 59, btn_inc -> 00 with hour unchanged. Then btn_mode -> mode 00 and sec_bcd = 00 on that edge. The next tick gives sec 01.
- btn_mode and btn_inc in the same cycle in RUN at 05:05:05 -> mode 01, hours still 05. Separately, tick and btn_mode in the same cycle in RUN -> sec 06 and mode 01.
- Assert sys_rst_p mid-count between clock edges with INIT 12:34:56 -> outputs show 12:34:56, mode 00 and ticks 0 before the next clk_100M edge. Holding clk_1Hz high across reset release must not generate a tick until clk_1Hz goes low and then high again.
